// File: rtl/ddr2ifc_txn_monitor_pkg.sv
// Shared definitions for the DDR2 command/data transaction monitor:
// command encodings, error codes and capture FSM states.
package ddr2ifc_txn_monitor_pkg;

   // {cs_n, ras_n, cas_n, we_n}
   localparam logic [3:0] CMD_ACT = 4'b0011;
   localparam logic [3:0] CMD_RD  = 4'b0101;
   localparam logic [3:0] CMD_WR  = 4'b0100;
   localparam logic [3:0] CMD_PRE = 4'b0010;

   typedef enum logic [2:0] {
      ERR_NONE     = 3'd0,
      ERR_CLOSED   = 3'd1,
      ERR_ACT_OPEN = 3'd2,
      ERR_TRCD     = 3'd3,
      ERR_TRP      = 3'd4,
      ERR_BUSY     = 3'd5,
      ERR_OVERFLOW = 3'd6
   } err_code_e;

   typedef enum logic [1:0] {
      CAP_IDLE     = 2'd0,
      CAP_WAIT_LAT = 2'd1,
      CAP_CAPTURE  = 2'd2
   } cap_state_e;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/ddr2ifc_txn_monitor_rec_fifo.sv
// First-word-fall-through record FIFO; head reads as zero while empty and
// a push into a full FIFO is only accepted when a pop happens that cycle.
module ddr2ifc_rec_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             ck,
   input  logic             reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data,
   output logic             o_drop
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;

   logic w_empty;
   logic w_full;
   logic w_pop;
   logic w_wr;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == (AW+1)'(DEPTH));
   assign w_pop   = i_pop & ~w_empty;
   assign w_wr    = i_push & (~w_full | w_pop);
   assign o_drop  = i_push & w_full & ~w_pop;
   assign o_valid = ~w_empty;
   assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];

   always_ff @(posedge ck) begin
      if (reset && w_wr) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge ck) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_wr, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/ddr2ifc_txn_monitor.sv
// Passive DDR2 bus monitor: tracks per-bank state, flags protocol errors and
// captures each legal RD/WR burst into a record FIFO.
module ddr2ifc_txn_monitor
   import ddr2ifc_txn_monitor_pkg::*;
#(
   parameter int DQ_W       = 16,
   parameter int BANKS      = 4,
   parameter int ROW_W      = 13,
   parameter int COL_W      = 10,
   parameter int BL         = 8,
   parameter int CL         = 4,
   parameter int T_RCD      = 3,
   parameter int T_RP       = 3,
   parameter int FIFO_DEPTH = 8,
   localparam int BA_W      = $clog2(BANKS)
) (
   input  logic                 ck,
   input  logic                 reset,
   input  logic                 cke,
   input  logic                 cs_n,
   input  logic                 ras_n,
   input  logic                 cas_n,
   input  logic                 we_n,
   input  logic [ROW_W-1:0]     addr,
   input  logic [BA_W-1:0]      ba,
   input  logic [2*DQ_W-1:0]    dq_pair,
   output logic                 rec_valid,
   input  logic                 rec_ready,
   output logic                 rec_is_wr,
   output logic [BA_W-1:0]      rec_bank,
   output logic [ROW_W-1:0]     rec_row,
   output logic [COL_W-1:0]     rec_col,
   output logic [BL*DQ_W-1:0]   rec_data,
   output logic                 err_pulse,
   output logic [2:0]           err_code,
   output logic [15:0]          err_count,
   output logic [15:0]          drop_count
);

   localparam int T_MAX  = (T_RCD > T_RP) ? T_RCD : T_RP;
   localparam int TMR_W  = (T_MAX > 2) ? $clog2(T_MAX) : 1;
   localparam int LAT_W  = $clog2(CL + 1);
   localparam int HALF   = BL / 2;
   localparam int BEAT_W = (HALF > 1) ? $clog2(HALF) : 1;
   localparam int DATA_W = BL * DQ_W;
   localparam int REC_W  = 1 + BA_W + ROW_W + COL_W + DATA_W;

   logic               r_cke_prev;
   logic [BANKS-1:0]   r_open;
   logic [ROW_W-1:0]   r_row   [BANKS];
   logic [TMR_W-1:0]   r_timer [BANKS];
   cap_state_e         r_state;
   cap_state_e         w_state_next;
   logic               r_cap_wr;
   logic [BA_W-1:0]    r_cap_bank;
   logic [ROW_W-1:0]   r_cap_row;
   logic [COL_W-1:0]   r_cap_col;
   logic [LAT_W-1:0]   r_lat;
   logic [BEAT_W-1:0]  r_beat;
   logic [DATA_W-1:0]  r_data;
   logic               r_err_pulse;
   logic [2:0]         r_err_code;
   logic [15:0]        r_err_count;
   logic [15:0]        r_drop_count;

   logic [3:0]         w_cmd;
   logic               w_cmd_en;
   logic               w_act;
   logic               w_rd;
   logic               w_wr;
   logic               w_pre;
   logic               w_rw;
   logic               w_ap;
   logic               w_open;
   logic               w_tmr_busy;
   logic               w_busy;
   logic               w_rw_ok;
   logic [LAT_W-1:0]   w_lat_load;
   err_code_e          w_err;
   logic               w_start;
   logic               w_cap_en;
   logic               w_push;
   logic               w_drop;
   logic [REC_W-1:0]   w_push_data;
   logic [REC_W-1:0]   w_head;

   assign w_cmd      = {cs_n, ras_n, cas_n, we_n};
   assign w_cmd_en   = cke & r_cke_prev;
   assign w_act      = w_cmd_en && (w_cmd == CMD_ACT);
   assign w_rd       = w_cmd_en && (w_cmd == CMD_RD);
   assign w_wr       = w_cmd_en && (w_cmd == CMD_WR);
   assign w_pre      = w_cmd_en && (w_cmd == CMD_PRE);
   assign w_rw       = w_rd | w_wr;
   assign w_ap       = addr[10];
   assign w_open     = r_open[ba];
   assign w_tmr_busy = (r_timer[ba] != '0);
   assign w_busy     = (r_state != CAP_IDLE);
   assign w_rw_ok    = w_rw & w_open & ~w_tmr_busy & ~w_busy;
   assign w_lat_load = w_rd ? LAT_W'(CL) : LAT_W'(CL - 1);

   // Checks are ordered by code so the first match is the lowest code.
   always_comb begin
      w_err = ERR_NONE;
      if (w_rw && !w_open)          w_err = ERR_CLOSED;
      else if (w_act && w_open)     w_err = ERR_ACT_OPEN;
      else if (w_rw && w_tmr_busy)  w_err = ERR_TRCD;
      else if (w_act && w_tmr_busy) w_err = ERR_TRP;
      else if (w_rw && w_busy)      w_err = ERR_BUSY;
      else if (w_drop)              w_err = ERR_OVERFLOW;
   end

   always_ff @(posedge ck) begin
      if (!reset) begin
         r_open <= '0;
         for (int b = 0; b < BANKS; b++) begin
            r_timer[b] <= '0;
            r_row[b]   <= '0;
         end
      end else begin
         for (int b = 0; b < BANKS; b++) begin
            if (r_timer[b] != '0) begin
               r_timer[b] <= r_timer[b] - 1'b1;
            end
            if (w_act && ba == BA_W'(b)) begin
               r_open[b]  <= 1'b1;
               r_row[b]   <= addr;
               r_timer[b] <= TMR_W'(T_RCD - 1);
            end else if ((w_pre && (w_ap || ba == BA_W'(b))) ||
                         (w_rw_ok && w_ap && ba == BA_W'(b))) begin
               r_open[b]  <= 1'b0;
               r_timer[b] <= TMR_W'(T_RP - 1);
            end
         end
      end
   end

   always_ff @(posedge ck) begin
      if (!reset) begin
         r_state <= CAP_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // r_lat reaching 1 on this edge means the next cycle is the first capture.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         CAP_IDLE: begin
            if (w_rw_ok) begin
               w_state_next = (w_lat_load == LAT_W'(1)) ? CAP_CAPTURE : CAP_WAIT_LAT;
            end
         end
         CAP_WAIT_LAT: begin
            if (r_lat <= LAT_W'(2)) w_state_next = CAP_CAPTURE;
         end
         CAP_CAPTURE: begin
            if (r_beat == BEAT_W'(HALF - 1)) w_state_next = CAP_IDLE;
         end
         default: w_state_next = CAP_IDLE;
      endcase
   end

   always_comb begin
      w_start  = 1'b0;
      w_cap_en = 1'b0;
      w_push   = 1'b0;
      case (r_state)
         CAP_IDLE:    w_start = w_rw_ok;
         CAP_CAPTURE: begin
            w_cap_en = 1'b1;
            w_push   = (r_beat == BEAT_W'(HALF - 1));
         end
         default: ;
      endcase
   end

   always_ff @(posedge ck) begin
      if (!reset) begin
         r_cap_wr   <= 1'b0;
         r_cap_bank <= '0;
         r_cap_row  <= '0;
         r_cap_col  <= '0;
         r_lat      <= '0;
         r_beat     <= '0;
         r_data     <= '0;
      end else begin
         if (w_start) begin
            r_cap_wr   <= w_wr;
            r_cap_bank <= ba;
            r_cap_row  <= r_row[ba];
            r_cap_col  <= addr[COL_W-1:0];
            r_lat      <= w_lat_load;
            r_beat     <= '0;
         end else if (r_state == CAP_WAIT_LAT) begin
            r_lat <= r_lat - 1'b1;
         end
         if (w_cap_en) begin
            r_data[int'(r_beat)*2*DQ_W +: 2*DQ_W] <= dq_pair;
            r_beat <= r_beat + 1'b1;
         end
      end
   end

   // Last beat pair goes straight into the record instead of via r_data.
   assign w_push_data = {r_cap_wr, r_cap_bank, r_cap_row, r_cap_col,
                         dq_pair, r_data[DATA_W-2*DQ_W-1:0]};

   ddr2ifc_rec_fifo #(
      .WIDTH (REC_W),
      .DEPTH (FIFO_DEPTH)
   ) u_rec_fifo (
      .ck      (ck),
      .reset   (reset),
      .i_push  (w_push),
      .i_data  (w_push_data),
      .i_pop   (rec_ready),
      .o_valid (rec_valid),
      .o_data  (w_head),
      .o_drop  (w_drop)
   );

   assign {rec_is_wr, rec_bank, rec_row, rec_col, rec_data} = w_head;

   always_ff @(posedge ck) begin
      if (!reset) begin
         r_cke_prev   <= 1'b0;
         r_err_pulse  <= 1'b0;
         r_err_code   <= 3'd0;
         r_err_count  <= 16'd0;
         r_drop_count <= 16'd0;
      end else begin
         r_cke_prev  <= cke;
         r_err_pulse <= (w_err != ERR_NONE);
         r_err_code  <= w_err;
         if (w_err != ERR_NONE) begin
            r_err_count <= sat_inc16(r_err_count);
         end
         if (w_drop) begin
            r_drop_count <= sat_inc16(r_drop_count);
         end
      end
   end

   assign err_pulse  = r_err_pulse;
   assign err_code   = r_err_code;
   assign err_count  = r_err_count;
   assign drop_count = r_drop_count;

endmodule

// File: tb/tb_ddr2ifc_txn_monitor.sv
// Directed scoreboard bench for ddr2ifc_txn_monitor at default parameters.
module tb_ddr2ifc_txn_monitor;

   localparam logic [3:0] ACT = 4'b0011;
   localparam logic [3:0] RD  = 4'b0101;
   localparam logic [3:0] WR  = 4'b0100;
   localparam logic [3:0] PRE = 4'b0010;
   localparam logic [31:0] IDLE_DQ = 32'hDEAD_BEEF;

   typedef struct packed {
      logic         is_wr;
      logic [1:0]   bank;
      logic [12:0]  row;
      logic [9:0]   col;
      logic [127:0] data;
   } rec_t;

   logic         ck = 1'b0;
   logic         reset, cke, cs_n, ras_n, cas_n, we_n, rec_ready;
   logic [12:0]  addr;
   logic [1:0]   ba;
   logic [31:0]  dq_pair;
   logic         rec_valid, rec_is_wr, err_pulse;
   logic [1:0]   rec_bank;
   logic [12:0]  rec_row;
   logic [9:0]   rec_col;
   logic [127:0] rec_data;
   logic [2:0]   err_code;
   logic [15:0]  err_count, drop_count;

   rec_t exp_rec_q[$];
   int   exp_err_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 ck = ~ck;

   ddr2ifc_txn_monitor dut (
      .ck (ck), .reset (reset), .cke (cke),
      .cs_n (cs_n), .ras_n (ras_n), .cas_n (cas_n), .we_n (we_n),
      .addr (addr), .ba (ba), .dq_pair (dq_pair),
      .rec_valid (rec_valid), .rec_ready (rec_ready),
      .rec_is_wr (rec_is_wr), .rec_bank (rec_bank), .rec_row (rec_row),
      .rec_col (rec_col), .rec_data (rec_data),
      .err_pulse (err_pulse), .err_code (err_code),
      .err_count (err_count), .drop_count (drop_count)
   );

   function automatic logic [127:0] beats(input logic [15:0] base);
      logic [127:0] d;
      for (int i = 0; i < 8; i++) d[16*i +: 16] = base + 16'(i);
      return d;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic exp_rec(input logic w, input logic [1:0] b, input logic [12:0] r,
                          input logic [9:0] c, input logic [15:0] base);
      rec_t e;
      e.is_wr = w; e.bank = b; e.row = r; e.col = c; e.data = beats(base);
      exp_rec_q.push_back(e);
   endtask

   // Records are checked at the handshake, error pulses right after the edge.
   task automatic step();
      rec_t e;
      if (rec_valid && rec_ready) begin
         if (exp_rec_q.size() == 0) begin
            chk("rec_unexpected", 128'(rec_valid), 128'd0);
         end else begin
            e = exp_rec_q.pop_front();
            chk("rec_is_wr", 128'(rec_is_wr), 128'(e.is_wr));
            chk("rec_bank",  128'(rec_bank),  128'(e.bank));
            chk("rec_row",   128'(rec_row),   128'(e.row));
            chk("rec_col",   128'(rec_col),   128'(e.col));
            chk("rec_data",  rec_data,        e.data);
            $display("record popped: wr=%0d bank=%0d row=%0h col=%0h", rec_is_wr, rec_bank, rec_row, rec_col);
         end
      end
      @(posedge ck); #1;
      if (err_pulse) begin
         if (exp_err_q.size() == 0) chk("err_unexpected", 128'(err_code), 128'd0);
         else chk("err_code", 128'(err_code), 128'(exp_err_q.pop_front()));
         $display("error pulse: code=%0d count=%0d", err_code, err_count);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic cmd(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a);
      {cs_n, ras_n, cas_n, we_n} = c;
      ba = b;
      addr = a;
      step();
      {cs_n, ras_n, cas_n, we_n} = 4'b1111;
      ba = 2'd0;
      addr = 13'd0;
   endtask

   task automatic burst(input logic [15:0] base);
      for (int k = 0; k < 4; k++) begin
         dq_pair = {base + 16'(2*k + 1), base + 16'(2*k)};
         step();
      end
      dq_pair = IDLE_DQ;
   endtask

   initial begin
      reset = 1'b0; cke = 1'b0; {cs_n, ras_n, cas_n, we_n} = 4'b1111;
      ba = 2'd0; addr = 13'd0; dq_pair = IDLE_DQ; rec_ready = 1'b0;
      idle(3);
      chk("rst_rec_valid",  128'(rec_valid),  128'd0);
      chk("rst_err_pulse",  128'(err_pulse),  128'd0);
      chk("rst_err_code",   128'(err_code),   128'd0);
      chk("rst_err_count",  128'(err_count),  128'd0);
      chk("rst_drop_count", 128'(drop_count), 128'd0);
      chk("rst_rec_data",   rec_data,         128'd0);
      chk("rst_rec_row",    128'(rec_row),    128'd0);
      reset = 1'b1; cke = 1'b1;
      idle(2);

      // Read: ACT b1, RD three cycles later, beats from command + CL.
      rec_ready = 1'b1;
      cmd(ACT, 2'd1, 13'h0ABC);
      idle(2);
      exp_rec(1'b0, 2'd1, 13'h0ABC, 10'h010, 16'h0000);
      cmd(RD, 2'd1, 13'h010);
      idle(3);
      burst(16'h0000);
      chk("rd_rec_valid", 128'(rec_valid), 128'd1);
      chk("rd_rec_data",  rec_data,        beats(16'h0000));
      idle(1);
      chk("rd_drained",   128'(rec_valid), 128'd0);

      // RD to a bank never activated.
      exp_err_q.push_back(1);
      cmd(RD, 2'd2, 13'h000);
      chk("closed_err_count", 128'(err_count), 128'd1);
      idle(1);
      chk("closed_pulse_width", 128'(err_pulse), 128'd0);
      idle(8);
      chk("closed_no_record", 128'(rec_valid), 128'd0);

      // tRCD violation, then ACT to an open bank (row still updated).
      cmd(ACT, 2'd0, 13'h0100);
      exp_err_q.push_back(3);
      cmd(RD, 2'd0, 13'h020);
      exp_err_q.push_back(2);
      cmd(ACT, 2'd0, 13'h0155);
      chk("act_err_count", 128'(err_count), 128'd3);
      idle(2);
      exp_rec(1'b1, 2'd0, 13'h0155, 10'h020, 16'h0100);
      cmd(WR, 2'd0, 13'h020);
      idle(2);
      burst(16'h0100);
      chk("wr_rec_valid", 128'(rec_valid), 128'd1);
      idle(1);

      // Fill the FIFO with the consumer stalled; the ninth record is dropped.
      rec_ready = 1'b0;
      for (int j = 0; j < 9; j++) begin
         if (j < 8) exp_rec(1'b1, 2'd0, 13'h0155, 10'(j), {j[7:0], 8'h00});
         else exp_err_q.push_back(6);
         cmd(WR, 2'd0, 13'(j));
         idle(2);
         burst({j[7:0], 8'h00});
      end
      chk("ovf_drop_count", 128'(drop_count), 128'd1);
      chk("ovf_err_count",  128'(err_count),  128'd4);
      chk("ovf_head_col",   128'(rec_col),    128'd0);
      rec_ready = 1'b1;
      idle(8);
      chk("ovf_drained",    128'(rec_valid),  128'd0);
      chk("ovf_sb_left",    128'(exp_rec_q.size()), 128'd0);

      // Precharge-all closes every bank and arms tRP.
      cmd(PRE, 2'd0, 13'h400);
      idle(3);
      cmd(ACT, 2'd0, 13'h0001);
      cmd(ACT, 2'd3, 13'h0002);
      idle(3);
      cmd(PRE, 2'd0, 13'h400);
      exp_err_q.push_back(4);
      cmd(ACT, 2'd3, 13'h0002);
      chk("trp_err_count", 128'(err_count), 128'd5);
      idle(3);
      exp_err_q.push_back(1);
      cmd(RD, 2'd0, 13'h000);
      chk("pre_all_closed_count", 128'(err_count), 128'd6);
      idle(3);

      // RD with cke low is ignored.
      cmd(ACT, 2'd2, 13'h0333);
      idle(3);
      cke = 1'b0;
      cmd(RD, 2'd2, 13'h005);
      cke = 1'b1;
      idle(10);
      chk("cke_no_record",   128'(rec_valid), 128'd0);
      chk("cke_err_count",   128'(err_count), 128'd6);

      // Reset in the middle of a capture abandons the burst.
      cmd(RD, 2'd2, 13'h006);
      idle(5);
      reset = 1'b0;
      step();
      chk("midrst_rec_valid", 128'(rec_valid), 128'd0);
      chk("midrst_err_count", 128'(err_count), 128'd0);
      reset = 1'b1;
      idle(12);
      chk("midrst_no_record", 128'(rec_valid), 128'd0);

      // Capture path still works after the abandoned burst.
      cmd(ACT, 2'd1, 13'h0077);
      idle(2);
      exp_rec(1'b0, 2'd1, 13'h0077, 10'h005, 16'h0200);
      cmd(RD, 2'd1, 13'h005);
      idle(3);
      burst(16'h0200);
      idle(3);

      chk("end_rec_sb_left", 128'(exp_rec_q.size()), 128'd0);
      chk("end_err_sb_left", 128'(exp_err_q.size()), 128'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ddr2ifc_txn_monitor.md
DDR2IFC_TXN_MONITOR -- requirements
Module: ddr2ifc_txn_monitor

Interface
REQ-001 Parameter DQ_W, default 16: DRAM data width.
REQ-002 Parameter BANKS, default 4: bank count (power of 2); BA_W = clog2(BANKS).
REQ-003 Parameters ROW_W, default 13, and COL_W, default 10: row and column address widths.
REQ-004 Parameter BL, default 8: burst length (4 or 8).
REQ-005 Parameters CL, default 4 (read latency, cycles) and T_RCD, default 3, and T_RP, default 3 (cycles): DRAM timing.
REQ-006 Parameter FIFO_DEPTH, default 8: record FIFO depth (power of 2).
REQ-007 ck  input  1  monitor clock; all logic on posedge.
REQ-008 reset  input  1  reset, synchronous, active-low.
REQ-009 cke  input  1  clock enable from controller.
REQ-010 cs_n, ras_n, cas_n, we_n  input  1 each  command bits.
REQ-011 addr  input  ROW_W  row/column address; addr[10] is auto/all-precharge.
REQ-012 ba  input  BA_W  bank address.
REQ-013 dq_pair  input  2*DQ_W  PHY-captured beats per ck: [DQ_W-1:0] rising, upper half falling.
REQ-014 rec_valid  output  1; rec_ready  input  1: record handshake.
REQ-015 rec_is_wr  output  1; rec_bank  output  BA_W; rec_row  output  ROW_W; rec_col  output  COL_W; rec_data  output  BL*DQ_W (beat 0 in LSBs).
REQ-016 err_pulse  output  1; err_code  output  3: one-cycle protocol error report.
REQ-017 err_count  output  16; drop_count  output  16: saturating counters.

Function
REQ-018 Commands decoded only on cycles with cke=1 and previous-cycle cke=1; cs_n=1 or NOP ignored.
REQ-019 Encodings {cs_n,ras_n,cas_n,we_n}: ACT 0011, RD 0101, WR 0100, PRE 0010.
REQ-020 Per-bank table: open flag, open row, countdown timer; ACT sets open, row=addr, timer=T_RCD-1.
REQ-021 PRE with addr[10]=1 closes all banks; addr[10]=0 closes bank ba; closed bank timer=T_RP-1.
REQ-022 Timers decrement to 0 each cycle and saturate at 0.
REQ-023 Error codes: 1 RD/WR to closed bank; 2 ACT to open bank; 3 RD/WR with timer≠0 (tRCD); 4 ACT with timer≠0 (tRP); 5 RD/WR while capture busy; 6 FIFO overflow.
REQ-024 Multiple errors same cycle: lowest code reported; err_count increments by 1.
REQ-025 Erroneous RD/WR (codes 1,3,5) not captured; ACT with code 2 or 4 still updates row.
REQ-026 Capture FSM states IDLE, WAIT_LAT, CAPTURE.
REQ-027 IDLE→WAIT_LAT on valid RD/WR; latch bank, row from table, col=addr[COL_W-1:0], kind; load latency counter = CL (read) or CL-1 (write).
REQ-028 WAIT_LAT decrements; at 1 enters CAPTURE next cycle; latency 1 enters CAPTURE directly.
REQ-029 CAPTURE stores dq_pair into beats 2k,2k+1 for cycle k, BL/2 cycles, then pushes record, returns IDLE.
REQ-030 First capture cycle is exactly CL (read) or CL-1 (write) cycles after the command cycle.
REQ-031 RD/WR with addr[10]=1 (auto-precharge) closes bank at command cycle, timer=T_RP-1.
REQ-032 FIFO: push at capture end; pop when rec_valid&&rec_ready; simultaneous push/pop on full succeeds.
REQ-033 Push when full without pop: record dropped, drop_count++, error code 6.
REQ-034 rec_* driven from FIFO head, stable while rec_valid=1 and rec_ready=0.
REQ-035 Counters saturate at 0xFFFF.

Reset
REQ-036 reset=0 at posedge: FSM IDLE, banks closed, timers 0, FIFO empty, rec_valid=0, err_pulse=0, err_code=0, counters 0, cke history 0.
REQ-037 Reset mid-capture abandons burst; no record pushed.
REQ-038 rec_data/rec_bank/rec_row/rec_col/rec_is_wr = 0 while FIFO empty.

Structure
REQ-039 Shared package holds command encoding constants, error code enum, and capture state typedef.
REQ-040 Record FIFO is sub-module ddr2ifc_rec_fifo (parametrised width/depth, first-word-fall-through).

Verification
REQ-041 ACT b1 row 0x0ABC; 3 cycles later RD col 0x010; dq_pair 0x0001_0000..0x0007_0006 from cycle +4 → one record rd, b1, 0x0ABC, 0x010, beats 0..7.
REQ-042 RD b2 with no ACT → err_pulse 1 cycle, err_code 1, err_count 1, no record.
REQ-043 ACT b0, RD b0 next cycle → err_code 3; ACT b0 twice → err_code 2.
REQ-044 rec_ready=0, 9 writes at default depth → 8 records held, drop_count 1, err_code 6; then ready=1 drains 8 in order.
REQ-045 PRE addr[10]=1 after opening b0,b3 → both closed; ACT b3 next cycle → err_code 4.
REQ-046 cke=0 during a RD command → ignored; reset=0 mid-capture → rec_valid 0, FSM IDLE.
